// File: rtl/zone_pkg.sv
// Shared definitions for the zone brightness statistics block.
// Holds the zone geometry defaults, accumulator/multiplier widths, the
// minimum horizontal blanking after a zone-row, the FSM state type and
// the per-pixel max(R,G,B) helper.
package zone_pkg;

  localparam int DATA_W    = 8;
  localparam int ZONE_COLS = 24;
  localparam int ZONE_ROWS = 15;
  localparam int ZONE_NUM  = ZONE_COLS * ZONE_ROWS;
  localparam int CNT_W     = 9;
  localparam int SUM_W     = 21;   // 5760 * 255 < 2^21
  localparam int RECIP_W   = 24;
  localparam int RECIP_SH  = 23;
  localparam int MIN_BLANK = 28;
  localparam int GAP_W     = 5;

  typedef enum logic [1:0] {IDLE, ACTIVE, DUMP} state_t;

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/zone_acc_bank.sv
// Accumulator bank: one peak/sum slot per zone column of the current
// zone-row.
//   clk            : clock
//   clr_all        : clear every slot (frame start)
//   acc_en/idx/val : fold a pixel value into slot acc_idx (peak = max, sum += val)
//   rd_en/rd_idx   : read-and-clear port; rd_peak/rd_sum show slot rd_idx
//                    combinationally, the slot is zeroed at the clock edge
module zone_acc_bank
  import zone_pkg::*;
#(
  parameter int N_SLOTS = ZONE_COLS,
  parameter int IDX_W   = $clog2(N_SLOTS)
) (
  input  logic              clk,
  input  logic              clr_all,
  input  logic              acc_en,
  input  logic [IDX_W-1:0]  acc_idx,
  input  logic [DATA_W-1:0] acc_val,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_peak,
  output logic [SUM_W-1:0]  rd_sum
);

  logic [DATA_W-1:0] peak_q [N_SLOTS];
  logic [SUM_W-1:0]  sum_q  [N_SLOTS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SLOTS; i++) begin
      if (clr_all || (rd_en && rd_idx == IDX_W'(i))) begin
        peak_q[i] <= '0;
        sum_q[i]  <= '0;
      end else if (acc_en && acc_idx == IDX_W'(i)) begin
        if (acc_val > peak_q[i]) peak_q[i] <= acc_val;
        sum_q[i] <= sum_q[i] + SUM_W'(acc_val);
      end
    end
  end

  assign rd_peak = peak_q[rd_idx];
  assign rd_sum  = sum_q[rd_idx];

endmodule

// File: rtl/zone_luma_stat.sv
// Per-zone brightness statistics for the backlight frame buffer.
// Reduces each pixel to max(R,G,B), accumulates peak and sum per zone for
// one zone-row, then streams the 24 zone values of that row out during the
// following horizontal blanking.
//   i_pix_clk, rst      : clock, synchronous active-high reset
//   i_vs, i_de          : frame start (rising edge), data enable
//   i_r/i_g/i_b         : pixel colour
//   i_stat_mode         : 0 = peak, 1 = mean (latched at frame start)
//   light_reg_flatted   : zone value, valid with flag_done
//   cnt_360             : zone index, one cycle ahead of the value
//   flag_done           : write strobe, 24 cycles per zone-row
//   o_frame_done        : pulse the cycle after zone 359 is written
//   o_overrun           : sticky; a line started before the dump had room
module zone_luma_stat
  import zone_pkg::*;
#(
  parameter int H_ACT     = 1920,
  parameter int V_ACT     = 1080,
  parameter int ZONE_COLS = zone_pkg::ZONE_COLS,
  parameter int ZONE_ROWS = zone_pkg::ZONE_ROWS,
  parameter int RECIP     = 1456
) (
  input  logic              i_pix_clk,
  input  logic              rst,
  input  logic              i_vs,
  input  logic              i_de,
  input  logic [DATA_W-1:0] i_r,
  input  logic [DATA_W-1:0] i_g,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_stat_mode,
  output logic [DATA_W-1:0] light_reg_flatted,
  output logic [CNT_W-1:0]  cnt_360,
  output logic              flag_done,
  output logic              o_frame_done,
  output logic              o_overrun
);

  localparam int ZW     = H_ACT / ZONE_COLS;
  localparam int ZH     = V_ACT / ZONE_ROWS;
  localparam int ZC_W   = $clog2(ZONE_COLS);
  localparam int ZR_W   = $clog2(ZONE_ROWS);
  localparam int PROD_W = SUM_W + RECIP_W;
  localparam int SH_W   = PROD_W - RECIP_SH;

  function automatic logic [DATA_W-1:0] sat_u8(input logic [SH_W-1:0] v);
    if (v > SH_W'(8'hFF)) return 8'hFF;
    return v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] mean_scale(input logic [SUM_W-1:0] s);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(s) * PROD_W'(RECIP);
    return sat_u8(prod[PROD_W-1:RECIP_SH]);
  endfunction

  state_t            state;
  logic              mode_q;
  logic              vs_p0, de_p0;
  logic [DATA_W-1:0] p_p0;
  logic [15:0]       px, ln;
  logic [ZC_W-1:0]   zc, rd_idx;
  logic [ZR_W-1:0]   zr;
  logic [CNT_W-1:0]  zbase;
  logic [GAP_W-1:0]  gap;
  logic              row_end_q;
  logic              vld_p1, last_p1, last_p2;
  logic [DATA_W-1:0] peak_p1;
  logic [SUM_W-1:0]  sum_p1;
  logic [DATA_W-1:0] rd_peak;
  logic [SUM_W-1:0]  rd_sum;
  logic              vs_rise, de_fall, de_rise, acc_en, rd_en;

  assign vs_rise = i_vs & ~vs_p0;
  assign de_fall = de_p0 & ~i_de;
  assign de_rise = i_de & ~de_p0;
  assign acc_en  = (state == ACTIVE) && de_p0 && !vs_rise;
  assign rd_en   = (state == DUMP) && !vs_rise;

  // ---- stage p0: input register, pixel reduced to max(R,G,B)
  always_ff @(posedge i_pix_clk) begin
    p_p0 <= max3(i_r, i_g, i_b);
  end

  always_ff @(posedge i_pix_clk) begin
    if (rst) begin
      vs_p0 <= 1'b0;
      de_p0 <= 1'b0;
    end else begin
      vs_p0 <= i_vs;
      de_p0 <= i_de;
    end
  end

  zone_acc_bank #(.N_SLOTS(ZONE_COLS), .IDX_W(ZC_W)) u_bank (
    .clk     (i_pix_clk),
    .clr_all (vs_rise),
    .acc_en  (acc_en),
    .acc_idx (zc),
    .acc_val (p_p0),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_peak (rd_peak),
    .rd_sum  (rd_sum)
  );

  // ---- stage p1: counters, FSM, read-and-clear of one slot per dump cycle
  always_ff @(posedge i_pix_clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      px        <= '0;
      zc        <= '0;
      ln        <= '0;
      zr        <= '0;
      zbase     <= '0;
      rd_idx    <= '0;
      gap       <= '0;
      row_end_q <= 1'b0;
      o_overrun <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      cnt_360   <= '0;
    end else begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      // gap = blanking cycles seen so far after the latest line end
      if (de_fall) gap <= GAP_W'(1);
      else if (!i_de && gap != '1) gap <= gap + 1'b1;

      if (vs_rise) begin
        state     <= ACTIVE;
        mode_q    <= i_stat_mode;
        px        <= '0;
        zc        <= '0;
        ln        <= '0;
        zr        <= '0;
        zbase     <= '0;
        rd_idx    <= '0;
        row_end_q <= 1'b0;
        o_overrun <= 1'b0;
      end else begin
        // Column counters keep running through a dump so dropped pixels
        // do not shift the rest of the line into the wrong zones.
        if (state != IDLE) begin
          if (de_fall) begin
            px <= '0;
            zc <= '0;
            ln <= (ln == 16'(ZH - 1)) ? '0 : ln + 1'b1;
          end else if (de_p0) begin
            if (px == 16'(ZW - 1)) begin
              px <= '0;
              zc <= zc + 1'b1;
            end else begin
              px <= px + 1'b1;
            end
          end
          if (de_rise) begin
            row_end_q <= 1'b0;
            if (row_end_q && gap < GAP_W'(MIN_BLANK)) o_overrun <= 1'b1;
          end
        end

        case (state)
          ACTIVE: begin
            if (de_fall && ln == 16'(ZH - 1)) begin
              state     <= DUMP;
              rd_idx    <= '0;
              row_end_q <= 1'b1;
            end
          end
          DUMP: begin
            vld_p1  <= 1'b1;
            cnt_360 <= zbase + CNT_W'(rd_idx);
            last_p1 <= (rd_idx == ZC_W'(ZONE_COLS - 1)) && (zr == ZR_W'(ZONE_ROWS - 1));
            if (rd_idx == ZC_W'(ZONE_COLS - 1)) begin
              if (zr == ZR_W'(ZONE_ROWS - 1)) begin
                state <= IDLE;
              end else begin
                zr    <= zr + 1'b1;
                zbase <= zbase + CNT_W'(ZONE_COLS);
                state <= ACTIVE;
              end
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (state == DUMP) begin
      peak_p1 <= rd_peak;
      sum_p1  <= rd_sum;
    end
  end

  // ---- stage p2: mean multiply / peak select into the output register
  always_ff @(posedge i_pix_clk) begin
    if (rst) begin
      light_reg_flatted <= '0;
      flag_done         <= 1'b0;
      last_p2           <= 1'b0;
      o_frame_done      <= 1'b0;
    end else begin
      flag_done    <= vld_p1;
      last_p2      <= last_p1;
      o_frame_done <= last_p2;
      if (vld_p1) light_reg_flatted <= mode_q ? mean_scale(sum_p1) : peak_p1;
    end
  end

endmodule

// File: tb/tb_zone_luma_stat.sv
module tb_zone_luma_stat;

  localparam int H     = 48;
  localparam int V     = 30;
  localparam int ZC    = 24;
  localparam int ZR    = 15;
  localparam int ZW    = H / ZC;
  localparam int ZH    = V / ZR;
  localparam int RECIP = 1 << 21;

  logic       clk = 1'b0;
  logic       rst, i_vs, i_de, i_stat_mode;
  logic [7:0] i_r, i_g, i_b;
  logic [7:0] light_reg_flatted;
  logic [8:0] cnt_360;
  logic       flag_done, o_frame_done, o_overrun;

  always #5 clk = ~clk;

  zone_luma_stat #(
    .H_ACT(H), .V_ACT(V), .ZONE_COLS(ZC), .ZONE_ROWS(ZR), .RECIP(RECIP)
  ) dut (
    .i_pix_clk         (clk),
    .rst               (rst),
    .i_vs              (i_vs),
    .i_de              (i_de),
    .i_r               (i_r),
    .i_g               (i_g),
    .i_b               (i_b),
    .i_stat_mode       (i_stat_mode),
    .light_reg_flatted (light_reg_flatted),
    .cnt_360           (cnt_360),
    .flag_done         (flag_done),
    .o_frame_done      (o_frame_done),
    .o_overrun         (o_overrun)
  );

  typedef struct packed {
    logic [8:0] idx;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b1;
  int         run_len = 0;
  int         fd_seen = 0;
  int         exp_fd = 0;
  int         stray = 0;
  int         last_idx = -1;
  logic [8:0] prev_cnt = '0;
  logic       prev_flag = 1'b0;

  logic [7:0] img_r [V][H];
  logic [7:0] img_g [V][H];
  logic [7:0] img_b [V][H];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fill_uniform(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        img_r[y][x] = r; img_g[y][x] = g; img_b[y][x] = b;
      end
  endtask

  task automatic fill_random();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        img_r[y][x] = 8'($urandom); img_g[y][x] = 8'($urandom); img_b[y][x] = 8'($urandom);
      end
  endtask

  // Reference model: per zone, peak and mean of max(R,G,B) over its ZW x ZH block.
  task automatic push_expect(input bit mode, input int nrows);
    for (int zr = 0; zr < nrows; zr++)
      for (int zc = 0; zc < ZC; zc++) begin
        int     pk;
        longint sum;
        longint m;
        exp_t   e;
        pk  = 0;
        sum = 0;
        for (int y = zr * ZH; y < (zr + 1) * ZH; y++)
          for (int x = zc * ZW; x < (zc + 1) * ZW; x++) begin
            int p;
            p = img_r[y][x];
            if (img_g[y][x] > p) p = img_g[y][x];
            if (img_b[y][x] > p) p = img_b[y][x];
            if (p > pk) pk = p;
            sum += p;
          end
        m = (sum * RECIP) >> 23;
        if (m > 255) m = 255;
        e.idx = 9'(zr * ZC + zc);
        e.val = mode ? 8'(m) : 8'(pk);
        exp_q.push_back(e);
      end
  endtask

  task automatic drive_frame(input bit mode, input int blank, input int nrows, input int rst_row);
    i_stat_mode = mode;
    i_vs = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_vs = 1'b0;
    check("overrun_cleared_at_vs", o_overrun, 0);
    i_stat_mode = 1'($urandom_range(0, 1));
    if (rst_row < 0) begin
      push_expect(mode, nrows);
      if (nrows == ZR) exp_fd++;
    end else begin
      mon_en = 1'b0;
    end
    repeat (3) begin @(posedge clk); #1; end
    for (int y = 0; y < nrows * ZH; y++) begin
      for (int x = 0; x < H; x++) begin
        i_de = 1'b1; i_r = img_r[y][x]; i_g = img_g[y][x]; i_b = img_b[y][x];
        @(posedge clk); #1;
      end
      i_de = 1'b0; i_r = '0; i_g = '0; i_b = '0;
      for (int c = 0; c < blank; c++) begin
        rst = (y == rst_row * ZH + ZH - 1) && (c == 5);
        @(posedge clk); #1;
        if (rst) begin
          check("rst_light", light_reg_flatted, 0);
          check("rst_cnt", cnt_360, 0);
          check("rst_flag", flag_done, 0);
          check("rst_frame_done", o_frame_done, 0);
          check("rst_overrun", o_overrun, 0);
          rst = 1'b0;
          mon_en = 1'b1;
        end
      end
    end
    repeat (40) begin @(posedge clk); #1; end
    if (rst_row < 0)
      check("overrun_after_frame", o_overrun, (blank < 28 && nrows > 1) ? 1 : 0);
  endtask

  // Monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      if (flag_done) begin
        run_len++;
        if (exp_q.size() == 0) begin
          stray++;
          $display("FAIL unexpected_write: idx %0d value %0d, expected no write", prev_cnt, light_reg_flatted);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("zone_index", prev_cnt, e.idx);
          check("zone_value", light_reg_flatted, e.val);
          last_idx = e.idx;
        end
      end else if (run_len != 0) begin
        check("flag_run_len", run_len, 24);
        run_len = 0;
      end
      if (o_frame_done) begin
        fd_seen++;
        check("frame_done_align", (prev_flag && last_idx == 359) ? 1 : 0, 1);
      end
    end else begin
      run_len = 0;
    end
    prev_cnt  = cnt_360;
    prev_flag = flag_done;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_vs = 1'b0; i_de = 1'b0; i_stat_mode = 1'b0;
    i_r = '0; i_g = '0; i_b = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("reset_light", light_reg_flatted, 0);
    check("reset_cnt", cnt_360, 0);
    check("reset_flag", flag_done, 0);
    check("reset_frame_done", o_frame_done, 0);
    check("reset_overrun", o_overrun, 0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    fill_uniform(8'h10, 8'h80, 8'h20);
    drive_frame(1'b0, 32, ZR, -1);
    drive_frame(1'b1, 32, ZR, -1);

    fill_uniform(8'h00, 8'h00, 8'h00);
    img_g[2][3] = 8'hFF;                 // zone 25: zone-row 1, column 1
    drive_frame(1'b0, 32, ZR, -1);
    drive_frame(1'b1, 32, ZR, -1);

    fill_uniform(8'h10, 8'h80, 8'h20);
    drive_frame(1'b0, 20, ZR, -1);       // short blanking

    fill_random();
    drive_frame(1'($urandom_range(0, 1)), 32, 6, -1);  // abandoned by the next i_vs
    drive_frame(1'b1, 32, ZR, -1);

    fill_random();
    drive_frame(1'b0, 32, ZR, 2);        // reset during the dump of zone-row 2
    drive_frame(1'b0, 32, ZR, -1);

    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("frame_done_count", fd_seen, exp_fd);
    check("stray_writes", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
